// File: rtl/acc_seq_ctrl.sv
// Counted, restartable accumulator job sequencer: clears the sum on start, adds exactly
// len_i operands from a valid/ready stream, keeps sticky carry/overflow, pulses done.
module acc_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             v_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             v_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  // Extra MSB of the widened add is the unsigned carry-out.
  always_comb begin
    add_full = {1'b0, sum_q} + {1'b0, in_data_i};
    sum_d    = add_full[WIDTH-1:0];
    ovf_d    = (sum_q[WIDTH-1] == in_data_i[WIDTH-1]) &&
               (sum_d[WIDTH-1] != sum_q[WIDTH-1]);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            cnt_q   <= len_i;
            state_q <= (len_i == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_valid_i) begin
            sum_q  <= sum_d;
            cout_q <= cout_q | add_full[WIDTH];
            v_q    <= v_q | ovf_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs decode the state register only: no input-to-output paths.
  assign in_ready_o = (state_q == ACC);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign sum_o      = sum_q;
  assign cout_o     = cout_q;
  assign v_o        = v_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed self-checking bench for acc_seq_ctrl with hand-computed expected values.
module tb_acc_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [3:0] len_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;
  logic       v_o;

  int n_checks = 0;
  int n_fail   = 0;

  acc_seq_ctrl #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .len_i     (len_i),
    .in_valid_i(in_valid_i),
    .in_data_i (in_data_i),
    .in_ready_o(in_ready_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sum_o     (sum_o),
    .cout_o    (cout_o),
    .v_o       (v_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [3:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
    len_i   = 4'd0;
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    tick();
    in_valid_i = 1'b0;
    in_data_i  = 8'hAA;
  endtask

  bit         vpat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] dpat [0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    int di;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    len_i      = 4'd0;
    in_valid_i = 1'b0;
    in_data_i  = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_sum", sum_o, 0);
    check_val("rst_cout", cout_o, 0);
    check_val("rst_v", v_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_ready", in_ready_o, 0);
    check_val("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    tick();
    check_val("idle_busy", busy_o, 0);

    // Job 1: 10+20+30
    start_job(4'd3);
    check_val("j1_busy", busy_o, 1);
    check_val("j1_sum_clr", sum_o, 0);
    check_val("j1_rdy0", in_ready_o, 1);
    feed(8'd10);
    check_val("j1_rdy1", in_ready_o, 1);
    check_val("j1_sum1", sum_o, 10);
    feed(8'd20);
    check_val("j1_rdy2", in_ready_o, 1);
    check_val("j1_sum2", sum_o, 30);
    feed(8'd30);
    check_val("j1_done", done_o, 1);
    check_val("j1_rdy_done", in_ready_o, 0);
    check_val("j1_busy_done", busy_o, 1);
    check_val("j1_sum", sum_o, 60);
    check_val("j1_cout", cout_o, 0);
    check_val("j1_v", v_o, 0);
    tick();
    check_val("j1_done_off", done_o, 0);
    check_val("j1_busy_off", busy_o, 0);
    check_val("j1_sum_hold", sum_o, 60);

    // Job 2: unsigned wrap, mixed signs
    start_job(4'd2);
    feed(8'd200);
    feed(8'd100);
    check_val("j2_done", done_o, 1);
    check_val("j2_sum", sum_o, 44);
    check_val("j2_cout", cout_o, 1);
    check_val("j2_v", v_o, 0);
    tick();

    // Job 3: signed overflow then carry, both sticky
    start_job(4'd3);
    check_val("j3_cout_clr", cout_o, 0);
    feed(8'd100);
    feed(8'd100);
    check_val("j3_sum2", sum_o, 200);
    check_val("j3_v2", v_o, 1);
    check_val("j3_cout2", cout_o, 0);
    feed(8'd56);
    check_val("j3_done", done_o, 1);
    check_val("j3_sum", sum_o, 0);
    check_val("j3_cout", cout_o, 1);
    check_val("j3_v", v_o, 1);
    tick();

    // Job 4: valid toggling; invalid cycles carry junk that must be ignored
    start_job(4'd4);
    check_val("j4_v_clr", v_o, 0);
    di = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid_i = vpat[i];
      in_data_i  = vpat[i] ? dpat[di] : 8'hFF;
      if (vpat[i]) di++;
      tick();
      if (i == 2) check_val("j4_stall_sum", sum_o, 1);
      if (i == 5) begin
        check_val("j4_sum6", sum_o, 6);
        check_val("j4_nodone6", done_o, 0);
        check_val("j4_rdy6", in_ready_o, 1);
      end
    end
    in_valid_i = 1'b0;
    check_val("j4_done", done_o, 1);
    check_val("j4_sum", sum_o, 10);
    tick();

    // Job 5: zero length
    start_job(4'd0);
    check_val("j5_done", done_o, 1);
    check_val("j5_rdy", in_ready_o, 0);
    check_val("j5_sum", sum_o, 0);
    check_val("j5_cout", cout_o, 0);
    check_val("j5_v", v_o, 0);
    tick();
    check_val("j5_idle", busy_o, 0);

    // Job 6: start during ACC is ignored
    start_job(4'd2);
    feed(8'd5);
    start_i    = 1'b1;
    len_i      = 4'd7;
    in_valid_i = 1'b1;
    in_data_i  = 8'd6;
    tick();
    start_i    = 1'b0;
    len_i      = 4'd0;
    in_valid_i = 1'b0;
    check_val("j6_done", done_o, 1);
    check_val("j6_sum", sum_o, 11);
    tick();
    check_val("j6_idle", busy_o, 0);

    // Job 7: asynchronous reset mid-job, then a fresh job
    start_job(4'd5);
    feed(8'd1);
    feed(8'd2);
    check_val("j7_sum2", sum_o, 3);
    in_valid_i = 1'b1;
    in_data_i  = 8'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("j7_rst_sum", sum_o, 0);
    check_val("j7_rst_busy", busy_o, 0);
    check_val("j7_rst_rdy", in_ready_o, 0);
    check_val("j7_rst_done", done_o, 0);
    in_valid_i = 1'b0;
    tick();
    check_val("j7_rst_nodone", done_o, 0);
    rst_n = 1'b1;
    tick();
    start_job(4'd1);
    feed(8'd7);
    check_val("j7_done", done_o, 1);
    check_val("j7_sum", sum_o, 7);
    tick();
    check_val("j7_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
